postprocess_writeback: RTL and testbench

POSTPROCESS_WRITEBACK -- requirements
Module: postprocess_writeback

---
 rtl/postprocess_writeback.sv | 195 +++++++++++++++++++
 tb/tb_postprocess_writeback.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/postprocess_writeback.sv
// postprocess_writeback: collects 3x3-filtered result pixels into two ping-pong
// row banks and drains each completed row to the memory controller as linear
// writes (row*OUT_COL+col) under a valid/ready style handshake.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   frame_start_i    starts one frame (honoured only when idle)
//   core_valid_i     core_data_i is a valid result pixel this cycle
//   core_data_i      8-bit result pixel
//   wr_ready_i       memory controller accepts the presented write
//   wr_en_o          write request
//   wr_addr_o        20-bit linear write address
//   wr_data_o        8-bit write pixel
//   row_done_o       one-cycle pulse after an output row has drained
//   frame_done_o     one-cycle pulse after all output rows have drained
//   busy_o           frame in progress
//   overflow_o       sticky: a pixel arrived while its bank was still full
module postprocess_writeback #(
  parameter int unsigned MAX_ROW = 540,
  parameter int unsigned MAX_COL = 540
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start_i,
  input  logic        core_valid_i,
  input  logic [7:0]  core_data_i,
  input  logic        wr_ready_i,
  output logic        wr_en_o,
  output logic [19:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        row_done_o,
  output logic        frame_done_o,
  output logic        busy_o,
  output logic        overflow_o
);

  localparam int unsigned OUT_COL = MAX_COL - 2;
  localparam int unsigned OUT_ROW = MAX_ROW - 2;
  localparam int unsigned COL_W   = (OUT_COL > 1) ? $clog2(OUT_COL) : 1;
  localparam int unsigned ROW_W   = (OUT_ROW > 1) ? $clog2(OUT_ROW + 1) : 1;
  localparam int unsigned ADDR_W  = 20;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state, state_n;
  logic [7:0]       mem [2][OUT_COL];
  logic [1:0]       full, full_n;
  logic             coll_bank, coll_bank_n;
  logic [COL_W-1:0] coll_col, coll_col_n;
  logic             drain_bank, drain_bank_n;
  logic [COL_W-1:0] drain_col, drain_col_n;
  logic [ROW_W-1:0] drain_row, drain_row_n;

  logic              wr_en_n;
  logic [ADDR_W-1:0] wr_addr_n;
  logic [7:0]        wr_data_n;
  logic              row_done_n;
  logic              overflow_n;

  logic frame_go, in_run, coll_last, capture, drop;
  logic xfer, drain_last, frame_end, present;

  // Event decode shared by the FSM and the datapath
  always_comb begin
    frame_go   = (state == ST_IDLE) && frame_start_i;
    in_run     = (state == ST_RUN);
    coll_last  = (coll_col == COL_W'(OUT_COL - 1));
    capture    = in_run && core_valid_i && !full[coll_bank];
    drop       = in_run && core_valid_i &&  full[coll_bank];
    xfer       = in_run && wr_en_o && wr_ready_i;
    drain_last = xfer && (drain_col == COL_W'(OUT_COL - 1));
    frame_end  = drain_last && (drain_row == ROW_W'(OUT_ROW - 1));
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // FSM next state
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (frame_start_i) state_n = ST_RUN;
      ST_RUN:  if (frame_end)     state_n = ST_DONE;
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // Collector/drainer next-state logic
  always_comb begin
    full_n       = full;
    coll_bank_n  = coll_bank;
    coll_col_n   = coll_col;
    drain_bank_n = drain_bank;
    drain_col_n  = drain_col;
    drain_row_n  = drain_row;
    wr_en_n      = wr_en_o;
    row_done_n   = 1'b0;
    overflow_n   = overflow_o;
    present      = 1'b0;
    wr_addr_n    = wr_addr_o;
    wr_data_n    = wr_data_o;

    if (frame_go) begin
      full_n       = '0;
      coll_bank_n  = 1'b0;
      coll_col_n   = '0;
      drain_bank_n = 1'b0;
      drain_col_n  = '0;
      drain_row_n  = '0;
      wr_en_n      = 1'b0;
      overflow_n   = 1'b0;
    end else if (in_run) begin
      if (drop) overflow_n = 1'b1;

      if (capture) begin
        coll_col_n = coll_last ? '0 : coll_col + COL_W'(1);
        if (coll_last) coll_bank_n = ~coll_bank;
      end

      if (xfer) begin
        if (drain_last) begin
          full_n[drain_bank] = 1'b0;
          row_done_n         = 1'b1;
          drain_row_n        = drain_row + ROW_W'(1);
          drain_bank_n       = ~drain_bank;
          drain_col_n        = '0;
          // Chain straight into the other bank only if it was already full
          wr_en_n            = !frame_end && full[~drain_bank];
          present            = wr_en_n;
        end else begin
          drain_col_n = drain_col + COL_W'(1);
          present     = 1'b1;
        end
      end else if (!wr_en_o && full[drain_bank]) begin
        wr_en_n     = 1'b1;
        drain_col_n = '0;
        present     = 1'b1;
      end

      // Applied after the clear so a set on the same bank wins
      if (capture && coll_last) full_n[coll_bank] = 1'b1;
    end else begin
      wr_en_n = 1'b0;
    end

    if (present) begin
      wr_addr_n = ADDR_W'(drain_row_n) * ADDR_W'(OUT_COL) + ADDR_W'(drain_col_n);
      wr_data_n = mem[drain_bank_n][drain_col_n];
    end
  end

  // Row bank storage; contents survive reset
  always_ff @(posedge clk) begin
    if (capture) mem[coll_bank][coll_col] <= core_data_i;
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full         <= '0;
      coll_bank    <= 1'b0;
      coll_col     <= '0;
      drain_bank   <= 1'b0;
      drain_col    <= '0;
      drain_row    <= '0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= '0;
      wr_data_o    <= '0;
      row_done_o   <= 1'b0;
      frame_done_o <= 1'b0;
      busy_o       <= 1'b0;
      overflow_o   <= 1'b0;
    end else begin
      full         <= full_n;
      coll_bank    <= coll_bank_n;
      coll_col     <= coll_col_n;
      drain_bank   <= drain_bank_n;
      drain_col    <= drain_col_n;
      drain_row    <= drain_row_n;
      wr_en_o      <= wr_en_n;
      wr_addr_o    <= wr_addr_n;
      wr_data_o    <= wr_data_n;
      row_done_o   <= row_done_n;
      frame_done_o <= (state_n == ST_DONE);
      busy_o       <= (state_n != ST_IDLE);
      overflow_o   <= overflow_n;
    end
  end

endmodule

// File: tb/tb_postprocess_writeback.sv
// Testbench for postprocess_writeback with a 5x6 input image (4x3 output).
// A transaction-level model predicts the write stream from the pixels that
// are kept, and a compare process checks the DUT on every falling edge.
module tb_postprocess_writeback;

  localparam int MR      = 5;
  localparam int MC      = 6;
  localparam int OUT_COL = MC - 2;
  localparam int OUT_ROW = MR - 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start_i = 1'b0;
  logic        core_valid_i = 1'b0;
  logic [7:0]  core_data_i = 8'd0;
  logic        wr_ready_i = 1'b1;
  logic        wr_en_o;
  logic [19:0] wr_addr_o;
  logic [7:0]  wr_data_o;
  logic        row_done_o;
  logic        frame_done_o;
  logic        busy_o;
  logic        overflow_o;

  postprocess_writeback #(.MAX_ROW(MR), .MAX_COL(MC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start_i(frame_start_i),
    .core_valid_i (core_valid_i),
    .core_data_i  (core_data_i),
    .wr_ready_i   (wr_ready_i),
    .wr_en_o      (wr_en_o),
    .wr_addr_o    (wr_addr_o),
    .wr_data_o    (wr_data_o),
    .row_done_o   (row_done_o),
    .frame_done_o (frame_done_o),
    .busy_o       (busy_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: actual timeout, expected completion", name);
  endtask

  // ---------------- model + compare process ----------------
  logic [19:0] q_addr[$];
  logic [7:0]  q_data[$];
  int          log_cyc[$];
  logic [19:0] log_addr[$];
  logic [7:0]  log_data[$];
  int cyc = 0;
  int last_valid_cyc = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;

  int m_mode = 0;          // 0 idle, 1 run, 2 done
  int m_coll_rows = 0;     // complete rows captured
  int m_drain_rows = 0;    // complete rows written
  int m_col = 0;
  int m_kept = 0;
  int m_row_xfers = 0;
  int held_pre;
  int old_mode;
  logic m_ovf = 1'b0;
  logic e_row_done = 1'b0;
  logic e_frame_done = 1'b0;
  logic e_busy = 1'b0;
  logic hold_pend = 1'b0;
  logic [19:0] hold_addr, ea;
  logic [7:0]  hold_data, ed;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      check("rst_wr_en", wr_en_o, 0);
      check("rst_wr_addr", wr_addr_o, 0);
      check("rst_wr_data", wr_data_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_overflow", overflow_o, 0);
      q_addr.delete(); q_data.delete();
      m_mode = 0; m_coll_rows = 0; m_drain_rows = 0; m_col = 0; m_kept = 0;
      m_row_xfers = 0; m_ovf = 1'b0; e_row_done = 1'b0; e_frame_done = 1'b0;
      e_busy = 1'b0; hold_pend = 1'b0;
    end else begin
      check("row_done", row_done_o, e_row_done);
      check("frame_done", frame_done_o, e_frame_done);
      check("busy", busy_o, e_busy);
      check("overflow", overflow_o, m_ovf);
      if (row_done_o) rd_cnt++;
      if (frame_done_o) fd_cnt++;
      if (hold_pend) begin
        check("hold_wr_en", wr_en_o, 1);
        check("hold_wr_addr", wr_addr_o, hold_addr);
        check("hold_wr_data", wr_data_o, hold_data);
      end
      if (m_coll_rows == m_drain_rows) check("no_row_wr_en", wr_en_o, 0);
      if (core_valid_i) last_valid_cyc = cyc;

      e_row_done = 1'b0;
      e_frame_done = 1'b0;
      old_mode = m_mode;
      held_pre = m_coll_rows - m_drain_rows;

      // write stream: every transfer must be the oldest kept pixel
      if (wr_en_o && wr_ready_i) begin
        log_cyc.push_back(cyc); log_addr.push_back(wr_addr_o); log_data.push_back(wr_data_o);
        if (q_addr.size() == 0) begin
          fail_timeout("unexpected_write");
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          check("wr_addr", wr_addr_o, ea);
          check("wr_data", wr_data_o, ed);
        end
        m_row_xfers++;
        if (m_row_xfers == OUT_COL) begin
          m_row_xfers = 0;
          m_drain_rows++;
          e_row_done = 1'b1;
          if (m_drain_rows == OUT_ROW) begin
            m_mode = 2;
            e_frame_done = 1'b1;
          end
        end
      end

      if (old_mode == 0) begin
        if (frame_start_i) begin
          m_mode = 1; m_coll_rows = 0; m_drain_rows = 0; m_col = 0; m_kept = 0;
          m_row_xfers = 0; m_ovf = 1'b0; q_addr.delete(); q_data.delete();
        end
      end else if (old_mode == 1) begin
        if (core_valid_i) begin
          // both banks hold undrained rows -> the collector bank is full
          if (held_pre == 2) m_ovf = 1'b1;
          else begin
            q_addr.push_back(20'(m_kept));
            q_data.push_back(core_data_i);
            m_kept++;
            m_col++;
            if (m_col == OUT_COL) begin
              m_col = 0;
              m_coll_rows++;
            end
          end
        end
      end else begin
        m_mode = 0;
      end

      e_busy = (m_mode != 0);
      hold_pend = wr_en_o && !wr_ready_i;
      hold_addr = wr_addr_o;
      hold_data = wr_data_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick_drive(input logic v, input logic [7:0] d);
    @(posedge clk); #1;
    core_valid_i = v;
    core_data_i  = d;
  endtask

  task automatic send_row(input int base, input int gap);
    for (int i = 0; i < OUT_COL; i++) tick_drive(1'b1, 8'(base + i));
    for (int i = 0; i < gap; i++) tick_drive(1'b0, 8'd0);
  endtask

  task automatic start_frame;
    @(posedge clk); #1 frame_start_i = 1'b1;
    @(posedge clk); #1 frame_start_i = 1'b0;
  endtask

  task automatic do_reset;
    @(posedge clk); #2;
    rst_n = 1'b0; core_valid_i = 1'b0; frame_start_i = 1'b0; wr_ready_i = 1'b1;
    #1;
    check("async_wr_en", wr_en_o, 0);
    check("async_wr_addr", wr_addr_o, 0);
    check("async_wr_data", wr_data_o, 0);
    check("async_row_done", row_done_o, 0);
    check("async_frame_done", frame_done_o, 0);
    check("async_busy", busy_o, 0);
    check("async_overflow", overflow_o, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (q_addr.size() == 0 && !wr_en_o) begin ok = 1; break; end
    end
    if (!ok) fail_timeout(name);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_log(input int n, input string name);
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (log_data.size() >= n) begin ok = 1; break; end
    end
    if (!ok) fail_timeout(name);
  endtask

  // ---------------- directed tests ----------------
  int b, r0, f0, n;

  initial begin
    do_reset();

    // single row: 10..13 written to 0..3 back-to-back
    start_frame();
    b = log_data.size(); r0 = rd_cnt;
    send_row(10, 1);
    wait_drain("row_drain_timeout");
    n = log_data.size() - b;
    check("row_count", n, 4);
    if (n >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("row_addr", log_addr[b+i], i);
        check("row_data", log_data[b+i], 10 + i);
        check("row_consecutive", log_cyc[b+i] - log_cyc[b], i);
      end
      check("row_latency", log_cyc[b] - last_valid_cyc, 2);
    end
    check("row_done_pulses", rd_cnt - r0, 1);
    do_reset();

    // full frame: pixels 0..11 paced row by row
    start_frame();
    b = log_data.size(); r0 = rd_cnt; f0 = fd_cnt;
    send_row(0, 2); send_row(4, 2); send_row(8, 2);
    wait_drain("frame_drain_timeout");
    n = log_data.size() - b;
    check("frame_count", n, 12);
    if (n >= 12) begin
      for (int i = 0; i < 12; i++) begin
        check("frame_addr", log_addr[b+i], i);
        check("frame_data", log_data[b+i], i);
      end
    end
    check("frame_row_done_pulses", rd_cnt - r0, 3);
    check("frame_done_pulses", fd_cnt - f0, 1);
    check("frame_busy_after", busy_o, 0);
    check("frame_overflow", overflow_o, 0);

    // backpressure: five stalled cycles mid-row
    start_frame();
    b = log_data.size();
    send_row(20, 1);
    wait_log(b + 2, "bp_start_timeout");
    @(posedge clk); #1 wr_ready_i = 1'b0;
    repeat (5) @(posedge clk);
    #1 wr_ready_i = 1'b1;
    wait_drain("bp_drain_timeout");
    n = log_data.size() - b;
    check("bp_count", n, 4);
    if (n >= 4) begin
      for (int i = 0; i < 4; i++) begin
        check("bp_addr", log_addr[b+i], i);
        check("bp_data", log_data[b+i], 20 + i);
      end
      check("bp_span", log_cyc[b+3] - log_cyc[b], 8);
    end
    do_reset();

    // overflow: nine pixels with the write port stalled
    start_frame();
    b = log_data.size();
    wr_ready_i = 1'b0;
    for (int i = 0; i < 9; i++) tick_drive(1'b1, 8'(30 + i));
    tick_drive(1'b0, 8'd0);
    @(negedge clk);
    check("ovf_set", overflow_o, 1);
    @(posedge clk); #1 wr_ready_i = 1'b1;
    wait_drain("ovf_drain_timeout");
    n = log_data.size() - b;
    check("ovf_count", n, 8);
    if (n >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check("ovf_addr", log_addr[b+i], i);
        check("ovf_data", log_data[b+i], 30 + i);
      end
    end
    check("ovf_sticky", overflow_o, 1);
    send_row(60, 1);
    wait_drain("ovf_last_row_timeout");
    check("ovf_sticky_idle", overflow_o, 1);
    start_frame();
    @(negedge clk);
    check("ovf_cleared", overflow_o, 0);

    // reset mid-frame after six pixels, then a fresh frame from address 0
    for (int i = 0; i < 6; i++) tick_drive(1'b1, 8'(40 + i));
    tick_drive(1'b0, 8'd0);
    do_reset();
    start_frame();
    b = log_data.size();
    send_row(50, 1);
    wait_drain("rst_drain_timeout");
    n = log_data.size() - b;
    check("rst_count", n, 4);
    if (n >= 4) begin
      check("rst_first_addr", log_addr[b], 0);
      check("rst_first_data", log_data[b], 50);
    end
    do_reset();

    // last drain of bank 0 coincides with last capture into bank 1
    start_frame();
    b = log_data.size();
    send_row(70, 1); send_row(74, 1);
    wait_drain("sim_drain_timeout");
    n = log_data.size() - b;
    check("sim_count", n, 8);
    if (n >= 8) begin
      for (int i = 0; i < 8; i++) check("sim_data", log_data[b+i], 70 + i);
      check("sim_gap_ok", (log_cyc[b+4] - log_cyc[b+3]) <= 2, 1);
    end
    check("sim_overflow", overflow_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual still running, expected finished");
    $fatal(1, "watchdog");
  end

endmodule
